reg_file_scoreboard: RTL and testbench

- Responder for the decoder's register-file request interface (rs1/rs2 with enables, rd with enable).
- Holds the 32-entry integer register file and a per-register busy scoreboard.
- Stalls decode on RAW/WAW hazards. Issues operand values to the execute stage through a registered valid/ready output.
- Accepts write-back from execute/memory, with same-cycle bypass.

---
 rtl/reg_file_scoreboard.sv | 141 ++++++++++++++
 tb/tb_reg_file_scoreboard.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   Register-file responder for the decoder. Holds the 32-entry integer
//   register file (x0 hardwired to zero) and a per-register busy scoreboard.
//   It stalls decode on RAW/WAW hazards and issues operands to execute
//   through a registered valid/ready slot. Write-back data bypasses into
//   operand selection and hazard checks in the same cycle.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   dec_valid / dec_ready    decoder request handshake (dec_ready is combinational)
//   rs1_en, rs1, rs2_en, rs2 source operand requests
//   rd_en, rd                destination of the requesting instruction
//   wb_valid, wb_rd, wb_data write-back port
//   flush                    drop the issued slot and clear all busy bits
//   out_valid / out_ready    issued-slot handshake toward execute
//   out_rs1_data, out_rs2_data, out_rd_en, out_rd   issued-slot payload
module reg_file_scoreboard #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic              rs1_en,
    input  logic [REG_AW-1:0] rs1,
    input  logic              rs2_en,
    input  logic [REG_AW-1:0] rs2,
    input  logic              rd_en,
    input  logic [REG_AW-1:0] rd,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rs1_data,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic              out_rd_en,
    output logic [REG_AW-1:0] out_rd
);

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;

    logic                out_valid_q, out_valid_d;
    logic [XLEN-1:0]     out_rs1_q, out_rs1_d;
    logic [XLEN-1:0]     out_rs2_q, out_rs2_d;
    logic                out_rd_en_q, out_rd_en_d;
    logic [REG_AW-1:0]   out_rd_q, out_rd_d;

    logic wb_we;
    logic wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
    logic haz_rs1, haz_rs2, haz_rd, hazard;
    logic issue;
    logic [XLEN-1:0] rs1_val, rs2_val;

    // A write-back to x0 is discarded, so it never counts as a hit.
    assign wb_we      = wb_valid && (wb_rd != '0);
    assign wb_hit_rs1 = wb_we && (wb_rd == rs1);
    assign wb_hit_rs2 = wb_we && (wb_rd == rs2);
    assign wb_hit_rd  = wb_we && (wb_rd == rd);

    // A busy register being written back this cycle is no longer a hazard.
    assign haz_rs1 = rs1_en && (rs1 != '0) && busy_q[rs1] && !wb_hit_rs1;
    assign haz_rs2 = rs2_en && (rs2 != '0) && busy_q[rs2] && !wb_hit_rs2;
    assign haz_rd  = rd_en  && (rd  != '0) && busy_q[rd]  && !wb_hit_rd;
    assign hazard  = haz_rs1 || haz_rs2 || haz_rd;

    assign dec_ready = !flush && !hazard && (!out_valid_q || out_ready);
    assign issue     = dec_valid && dec_ready;

    always_comb begin
        rs1_val = '0;
        if (rs1_en && (rs1 != '0))
            rs1_val = wb_hit_rs1 ? wb_data : regs_q[rs1];
        rs2_val = '0;
        if (rs2_en && (rs2 != '0))
            rs2_val = wb_hit_rs2 ? wb_data : regs_q[rs2];
    end

    // Clear from write-back is applied before set from issue so a new
    // producer of the same register keeps it busy; flush overrides both.
    always_comb begin
        busy_d = busy_q;
        if (wb_we)
            busy_d[wb_rd] = 1'b0;
        if (issue && rd_en && (rd != '0))
            busy_d[rd] = 1'b1;
        if (flush)
            busy_d = '0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_rs1_d   = out_rs1_q;
        out_rs2_d   = out_rs2_q;
        out_rd_en_d = out_rd_en_q;
        out_rd_d    = out_rd_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (issue) begin
            out_valid_d = 1'b1;
            out_rs1_d   = rs1_val;
            out_rs2_d   = rs2_val;
            out_rd_en_d = rd_en;
            out_rd_d    = rd;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q      <= '{default: '0};
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_rs1_q   <= '0;
            out_rs2_q   <= '0;
            out_rd_en_q <= 1'b0;
            out_rd_q    <= '0;
        end else begin
            if (wb_we)
                regs_q[wb_rd] <= wb_data;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_rs1_q   <= out_rs1_d;
            out_rs2_q   <= out_rs2_d;
            out_rd_en_q <= out_rd_en_d;
            out_rd_q    <= out_rd_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_rs1_data = out_rs1_q;
    assign out_rs2_data = out_rs2_q;
    assign out_rd_en    = out_rd_en_q;
    assign out_rd       = out_rd_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Testbench for reg_file_scoreboard: directed scenarios followed by a
// randomized phase, every cycle compared against a behavioural model.
module tb_reg_file_scoreboard;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NR   = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            dec_valid, dec_ready;
    logic            rs1_en, rs2_en, rd_en;
    logic [AW-1:0]   rs1, rs2, rd;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_rs1_data, out_rs2_data;
    logic            out_rd_en;
    logic [AW-1:0]   out_rd;

    always #5 clk = ~clk;

    reg_file_scoreboard #(.XLEN(XLEN), .REG_AW(AW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .rs1_en(rs1_en), .rs1(rs1), .rs2_en(rs2_en), .rs2(rs2),
        .rd_en(rd_en), .rd(rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd_en(out_rd_en), .out_rd(out_rd)
    );

    // Reference model: architectural registers, busy flags and the issued slot.
    logic [XLEN-1:0] m_reg [NR];
    bit              m_busy [NR];
    bit              m_valid;
    logic [XLEN-1:0] m_o1, m_o2;
    bit              m_rden;
    logic [AW-1:0]   m_rd;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_wbhit(input logic [AW-1:0] r);
        return wb_valid && (wb_rd == r) && (r != 0);
    endfunction

    function automatic bit m_stalled(input bit en, input logic [AW-1:0] r);
        return en && (r != 0) && m_busy[r] && !m_wbhit(r);
    endfunction

    function automatic bit m_ready();
        bit hz;
        hz = m_stalled(rs1_en, rs1) || m_stalled(rs2_en, rs2) || m_stalled(rd_en, rd);
        return !flush && !hz && (!m_valid || out_ready);
    endfunction

    function automatic logic [XLEN-1:0] m_opnd(input bit en, input logic [AW-1:0] r);
        if (!en || r == 0) return '0;
        if (m_wbhit(r))    return wb_data;
        return m_reg[r];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NR; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_o1    = '0;
        m_o2    = '0;
        m_rden  = 1'b0;
        m_rd    = '0;
    endtask

    task automatic idle();
        dec_valid = 1'b0; rs1_en = 1'b0; rs1 = '0; rs2_en = 1'b0; rs2 = '0;
        rd_en = 1'b0; rd = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1; rst = 1'b0;
    endtask

    task automatic req(input bit e1, input int r1, input bit e2, input int r2,
                       input bit ed, input int rdi);
        dec_valid = 1'b1;
        rs1_en = e1; rs1 = AW'(r1);
        rs2_en = e2; rs2 = AW'(r2);
        rd_en  = ed; rd  = AW'(rdi);
    endtask

    task automatic wb(input int r, input logic [XLEN-1:0] d);
        wb_valid = 1'b1; wb_rd = AW'(r); wb_data = d;
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_rs1_data", out_rs1_data, m_o1);
        check("out_rs2_data", out_rs2_data, m_o2);
        check("out_rd_en", 32'(out_rd_en), 32'(m_rden));
        check("out_rd", 32'(out_rd), 32'(m_rd));
    endtask

    // Called just after a falling edge with inputs already driven: checks
    // dec_ready, advances the model across the rising edge, checks outputs,
    // and returns at the next falling edge.
    task automatic tick();
        bit rdy, iss;
        logic [XLEN-1:0] n1, n2;
        #1;
        rdy = m_ready();
        iss = dec_valid && rdy;
        n1  = m_opnd(rs1_en, rs1);
        n2  = m_opnd(rs2_en, rs2);
        check("dec_ready", 32'(dec_ready), 32'(rdy));
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            if (flush) m_valid = 1'b0;
            else if (iss) begin
                m_valid = 1'b1; m_o1 = n1; m_o2 = n2; m_rden = rd_en; m_rd = rd;
            end else if (out_ready) m_valid = 1'b0;
            if (wb_valid && wb_rd != 0) begin
                m_reg[wb_rd]  = wb_data;
                m_busy[wb_rd] = 1'b0;
            end
            if (iss && rd_en && rd != 0) m_busy[rd] = 1'b1;
            if (flush)
                for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        end
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_reset();
        check_outputs();
        rst = 1'b0;

        // Reset state, then an issue with x0 sources and rd=5.
        idle(); tick();
        check("reset_dec_ready", 32'(dec_ready), 32'd1);
        req(1, 0, 1, 0, 1, 5); tick();
        check("first_issue_rd", 32'(out_rd), 32'd5);
        check("first_issue_valid", 32'(out_valid), 32'd1);
        idle(); req(1, 5, 0, 0, 0, 0); dec_valid = 1'b0; tick();
        check("x5_busy_stalls", 32'(dec_ready), 32'd0);

        // Write-back x5, then read it without stalling.
        idle(); wb(5, 32'h1234); tick();
        idle(); req(1, 5, 0, 0, 0, 0); tick();
        check("x5_readback", out_rs1_data, 32'h1234);

        // RAW stall on x7 resolved by bypass on the fourth cycle.
        idle(); req(0, 0, 0, 0, 1, 7); tick();
        idle(); req(0, 0, 1, 7, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 check("raw_stall", 32'(dec_ready), 32'd0);
            tick();
        end
        wb(7, 32'hDEADBEEF);
        #1 check("raw_release", 32'(dec_ready), 32'd1);
        tick();
        check("raw_bypass", out_rs2_data, 32'hDEADBEEF);

        // Backpressure: slot held for two cycles, then pending request accepted.
        idle(); out_ready = 1'b0; req(1, 7, 0, 0, 1, 12); tick();
        for (int i = 0; i < 2; i++) begin
            #1 check("bp_stall", 32'(dec_ready), 32'd0);
            tick();
            check("bp_hold_rs2", out_rs2_data, 32'hDEADBEEF);
        end
        out_ready = 1'b1; tick();
        check("bp_accept_rd", 32'(out_rd), 32'd12);

        // WAW with simultaneous set/clear on x3.
        idle(); req(0, 0, 0, 0, 1, 3); tick();
        idle(); req(0, 0, 0, 0, 1, 3); wb(3, 32'h3333); tick();
        idle(); req(1, 3, 0, 0, 0, 0); tick();
        check("x3_still_busy", 32'(dec_ready), 32'd0);
        idle(); wb(3, 32'h4444); tick();
        idle(); req(1, 3, 0, 0, 0, 0); tick();
        check("x3_value", out_rs1_data, 32'h4444);

        // x0 ignores writes and reads as zero.
        idle(); wb(0, 32'hFFFFFFFF); req(1, 0, 1, 0, 1, 0); tick();
        idle(); req(1, 0, 1, 0, 1, 0); tick();
        check("x0_rs1", out_rs1_data, 32'h0);
        check("x0_rs2", out_rs2_data, 32'h0);

        // Flush with x4 and x9 busy and a held slot.
        idle(); req(0, 0, 0, 0, 1, 4); tick();
        idle(); req(0, 0, 0, 0, 1, 9); tick();
        idle(); out_ready = 1'b0; flush = 1'b1; req(1, 4, 1, 9, 0, 0); tick();
        check("flush_valid", 32'(out_valid), 32'd0);
        idle(); req(1, 4, 1, 9, 0, 0); tick();
        check("flush_cleared_busy", 32'(out_valid), 32'd1);

        // Reset asserted in the middle of a stall.
        idle(); wb(10, 32'hABCD); tick();
        idle(); req(0, 0, 0, 0, 1, 10); tick();
        idle(); req(1, 10, 0, 0, 0, 0); tick();
        rst = 1'b1; tick();
        check("rst_clears_valid", 32'(out_valid), 32'd0);
        rst = 1'b0; tick();
        check("rst_dec_ready", 32'(dec_ready), 32'd1);
        check("rst_reg_cleared", out_rs1_data, 32'h0);

        // Randomized traffic on a small register window to provoke hazards.
        for (int n = 0; n < 500; n++) begin
            idle();
            dec_valid = 1'($urandom_range(0, 1));
            rs1_en = 1'($urandom_range(0, 1)); rs1 = AW'($urandom_range(0, 7));
            rs2_en = 1'($urandom_range(0, 1)); rs2 = AW'($urandom_range(0, 7));
            rd_en  = 1'($urandom_range(0, 1)); rd  = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) wb(int'($urandom_range(0, 7)), $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
